nn_infer_sequencer: RTL and testbench

//  Controller that owns the weight/bias configuration of the 2-2-1 XOR network datapath (NN) and

---
 rtl/nn_infer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_nn_infer_sequencer.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_infer_sequencer.sv
// Inference job sequencer for the 2-2-1 XOR network datapath.
// Holds weight/bias config, buffers operand pairs and returns thresholded results.
module nn_infer_sequencer #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64,
    localparam int dw = exp_width + mant_width
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [dw-1:0] cfg_wdata,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [dw-1:0] req_a,
    input  logic [dw-1:0] req_b,
    output logic [dw-1:0] nn_w11,
    output logic [dw-1:0] nn_w12,
    output logic [dw-1:0] nn_w21,
    output logic [dw-1:0] nn_w22,
    output logic [dw-1:0] nn_b1,
    output logic [dw-1:0] nn_b2,
    output logic [dw-1:0] nn_w31,
    output logic [dw-1:0] nn_w32,
    output logic [dw-1:0] nn_b3,
    output logic [2:0]    nn_round_mode,
    output logic [dw-1:0] nn_a,
    output logic [dw-1:0] nn_b,
    output logic          nn_start,
    input  logic          nn_ready,
    input  logic [dw-1:0] nn_result,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [dw-1:0] resp_data,
    output logic          resp_bit,
    output logic          resp_timeout,
    output logic          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    // 0.5 in the configured FP format: biased exponent of 2^-1, zero mantissa
    localparam logic [dw-2:0] HALF =
        (dw-1)'(2 ** (exp_width - 1) - 2) << (mant_width - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t state, state_n;

    logic [dw-1:0] cfg_q [9];
    logic [dw-1:0] fifo_a [FIFO_DEPTH];
    logic [dw-1:0] fifo_b [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic [CW-1:0] cnt;
    logic          empty, full, push, pop;
    logic          cap_ok, cap_to, cfg_ok, res_bit;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign req_ready = !full;
    assign push = req_valid && req_ready;
    assign cfg_ok = cfg_we && (state == IDLE) && empty;
    assign busy = (state != IDLE) || !empty;
    assign res_bit = !nn_result[dw-1] && (nn_result[dw-2:0] > HALF);

    assign nn_w11 = cfg_q[0];
    assign nn_w12 = cfg_q[1];
    assign nn_w21 = cfg_q[2];
    assign nn_w22 = cfg_q[3];
    assign nn_b1  = cfg_q[4];
    assign nn_b2  = cfg_q[5];
    assign nn_w31 = cfg_q[6];
    assign nn_w32 = cfg_q[7];
    assign nn_b3  = cfg_q[8];

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        cap_ok     = 1'b0;
        cap_to     = 1'b0;
        nn_start   = 1'b0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                nn_start = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                if (nn_ready) begin
                    cap_ok  = 1'b1;
                    state_n = RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    cap_to  = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Storage needs no reset; pointers alone define occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wptr[AW-1:0]] <= req_a;
            fifo_b[wptr[AW-1:0]] <= req_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            cnt           <= '0;
            nn_a          <= '0;
            nn_b          <= '0;
            resp_data     <= '0;
            resp_bit      <= 1'b0;
            resp_timeout  <= 1'b0;
            nn_round_mode <= 3'd0;
            for (int i = 0; i < 9; i++) cfg_q[i] <= '0;
        end else begin
            state <= state_n;
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                nn_a <= fifo_a[rptr[AW-1:0]];
                nn_b <= fifo_b[rptr[AW-1:0]];
                rptr <= rptr + 1'b1;
            end
            if (nn_start) cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (cap_ok) begin
                resp_data    <= nn_result;
                resp_bit     <= res_bit;
                resp_timeout <= 1'b0;
            end else if (cap_to) begin
                resp_data    <= '0;
                resp_bit     <= 1'b0;
                resp_timeout <= 1'b1;
            end
            if (cfg_ok) begin
                if (cfg_addr < 4'd9) cfg_q[cfg_addr] <= cfg_wdata;
                else if (cfg_addr == 4'd9) nn_round_mode <= cfg_wdata[2:0];
            end
        end
    end

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Directed bench for nn_infer_sequencer with a behavioural latency model of the
// network datapath (real-valued XOR net or a queue of canned results).
module tb_nn_infer_sequencer;

    localparam logic [31:0] ONE = 32'h3F800000;
    localparam logic [31:0] W4  = 32'h40800000;
    localparam logic [31:0] WM4 = 32'hC0800000;
    localparam logic [31:0] BM2 = 32'hC0000000;
    localparam logic [31:0] B6  = 32'h40C00000;
    localparam logic [31:0] BM6 = 32'hC0C00000;

    logic        clk = 0;
    logic        rst_l = 0;
    logic        cfg_we = 0;
    logic [3:0]  cfg_addr = 0;
    logic [31:0] cfg_wdata = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic [31:0] req_a = 0, req_b = 0;
    logic [31:0] nn_w11, nn_w12, nn_w21, nn_w22, nn_b1, nn_b2;
    logic [31:0] nn_w31, nn_w32, nn_b3;
    logic [2:0]  nn_round_mode;
    logic [31:0] nn_a, nn_b;
    logic        nn_start;
    logic        nn_ready;
    logic [31:0] nn_result;
    logic        resp_valid;
    logic        resp_ready = 0;
    logic [31:0] resp_data;
    logic        resp_bit, resp_timeout, busy;

    int total = 0;
    int bad = 0;

    int          model_lat = 1;
    bit          model_never = 0;
    bit          xor_mode = 0;
    logic [31:0] res_q[$];
    logic [31:0] exp_q[$];
    int          start_cnt = 0;

    nn_infer_sequencer dut (
        .clk(clk), .rst_l(rst_l),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .nn_w11(nn_w11), .nn_w12(nn_w12), .nn_w21(nn_w21), .nn_w22(nn_w22),
        .nn_b1(nn_b1), .nn_b2(nn_b2), .nn_w31(nn_w31), .nn_w32(nn_w32),
        .nn_b3(nn_b3), .nn_round_mode(nn_round_mode),
        .nn_a(nn_a), .nn_b(nn_b), .nn_start(nn_start),
        .nn_ready(nn_ready), .nn_result(nn_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_bit(resp_bit),
        .resp_timeout(resp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic real sig(real x);
        return 1.0 / (1.0 + $exp(-x));
    endfunction

    function automatic logic [31:0] to_f32(real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] xor_eval(logic [31:0] a, logic [31:0] b);
        real x, y, h1, h2;
        x = (a == ONE) ? 1.0 : 0.0;
        y = (b == ONE) ? 1.0 : 0.0;
        h1 = sig(4.0 * x + 4.0 * y - 2.0);
        h2 = sig(-4.0 * x - 4.0 * y + 6.0);
        return to_f32(sig(4.0 * h1 + 4.0 * h2 - 6.0));
    endfunction

    // Datapath model: nn_ready pulses model_lat cycles after nn_start
    initial begin
        int down;
        logic [31:0] ma, mb, r;
        down = 0;
        ma = 0;
        mb = 0;
        nn_ready = 0;
        nn_result = 0;
        forever begin
            @(negedge clk);
            nn_ready = 0;
            if (!rst_l) begin
                down = 0;
            end else if (nn_start) begin
                start_cnt++;
                down = model_lat;
                ma = nn_a;
                mb = nn_b;
            end else if (down > 0) begin
                down--;
                if (down == 0 && !model_never) begin
                    if (xor_mode) begin
                        r = xor_eval(ma, mb);
                        exp_q.push_back(r);
                    end else begin
                        r = (res_q.size() > 0) ? res_q.pop_front() : 32'h0;
                    end
                    nn_result = r;
                    nn_ready = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_l = 0;
        @(negedge clk);
        @(negedge clk);
        rst_l = 1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1;
        cfg_addr = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, output bit ok);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (ok) begin
            req_valid = 1;
            req_a = a;
            req_b = b;
            @(negedge clk);
            req_valid = 0;
        end
    endtask

    task automatic take_resp(output logic [31:0] d, output logic bt,
                             output logic to, output bit ok);
        ok = 0;
        d = 'x;
        bt = 'x;
        to = 'x;
        resp_ready = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = resp_valid;
        end
        if (ok) begin
            d = resp_data;
            bt = resp_bit;
            to = resp_timeout;
            resp_ready = 1;
            @(negedge clk);
            resp_ready = 0;
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = nn_start;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, req_ready, resp_valid, nn_start, resp_bit, resp_timeout} !== 6'b010000) begin
            bad++;
            $display("FAIL reset_ctrl: got busy/rdy/vld/start/bit/to=%b want 010000",
                     {busy, req_ready, resp_valid, nn_start, resp_bit, resp_timeout});
        end
        total++;
        if ({nn_w11, nn_b3, nn_a, nn_b, resp_data, nn_round_mode} !== '0) begin
            bad++;
            $display("FAIL reset_regs: got w11=%h b3=%h a=%h b=%h data=%h rm=%0d want 0",
                     nn_w11, nn_b3, nn_a, nn_b, resp_data, nn_round_mode);
        end
    endtask

    task automatic test_xor();
        logic [31:0] cfg [9];
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic [3:0]  exp_bits;
        logic [31:0] d, e;
        logic bt, to;
        bit ok;
        cfg = '{W4, W4, WM4, WM4, BM2, B6, W4, W4, BM6};
        pa = '{32'h0, 32'h0, ONE, ONE};
        pb = '{32'h0, ONE, 32'h0, ONE};
        exp_bits = 4'b0110;
        for (int i = 0; i < 9; i++) cfg_write(4'(i), cfg[i]);
        cfg_write(4'd9, 32'hFFFF_FFF1);
        total++;
        if ({nn_w11, nn_w12, nn_w21, nn_w22, nn_b1, nn_b2, nn_w31, nn_w32, nn_b3}
            !== {W4, W4, WM4, WM4, BM2, B6, W4, W4, BM6}) begin
            bad++;
            $display("FAIL xor_cfg: got %h %h %h %h %h %h %h %h %h", nn_w11, nn_w12,
                     nn_w21, nn_w22, nn_b1, nn_b2, nn_w31, nn_w32, nn_b3);
        end
        total++;
        if (nn_round_mode !== 3'd1) begin
            bad++;
            $display("FAIL xor_round_mode: got %0d want 1", nn_round_mode);
        end
        xor_mode = 1;
        model_never = 0;
        model_lat = 3;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            push(pa[i], pb[i], ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL xor_push%0d: req_ready never high", i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            take_resp(d, bt, to, ok);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            total++;
            if (!ok || bt !== exp_bits[3-i] || to !== 1'b0 || d !== e) begin
                bad++;
                $display("FAIL xor_resp%0d: got ok=%0d bit=%b to=%b data=%h want bit=%b to=0 data=%h",
                         i, ok, bt, to, d, exp_bits[3-i], e);
            end
        end
        xor_mode = 0;
    endtask

    task automatic test_threshold();
        logic [31:0] vals [5];
        logic [4:0]  exp_bits;
        logic [31:0] d;
        logic bt, to;
        bit ok;
        vals = '{32'h3F000000, 32'hBF800000, 32'h3F000001, 32'h80000000, 32'h3F800000};
        exp_bits = 5'b00101;
        model_never = 0;
        model_lat = 2;
        res_q.delete();
        for (int i = 0; i < 5; i++) res_q.push_back(vals[i]);
        push(32'h1, 32'h2, ok);
        total++;
        if (!ok || nn_start !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL thr_latency_a: got ok=%0d start=%b busy=%b want 1 0 1",
                     ok, nn_start, busy);
        end
        @(negedge clk);
        total++;
        if (nn_start !== 1'b1 || nn_a !== 32'h1 || nn_b !== 32'h2) begin
            bad++;
            $display("FAIL thr_latency_b: got start=%b a=%h b=%h want 1 1 2",
                     nn_start, nn_a, nn_b);
        end
        for (int i = 1; i < 5; i++) push(32'(i + 1), 32'h0, ok);
        for (int i = 0; i < 5; i++) begin
            take_resp(d, bt, to, ok);
            total++;
            if (!ok || bt !== exp_bits[4-i] || to !== 1'b0 || d !== vals[i]) begin
                bad++;
                $display("FAIL thr_resp%0d: got ok=%0d bit=%b to=%b data=%h want bit=%b to=0 data=%h",
                         i, ok, bt, to, d, exp_bits[4-i], vals[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] d;
        logic bt, to;
        bit ok;
        int sc;
        model_never = 0;
        model_lat = 1;
        res_q.delete();
        res_q.push_back(32'h3F400000);
        res_q.push_back(32'h3F000000);
        push(32'hA, 32'hB, ok);
        push(32'hC, 32'hD, ok);
        resp_ready = 0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = resp_valid;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_valid: resp_valid never rose");
        end
        sc = start_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({resp_valid, resp_bit, resp_timeout, resp_data} !== {3'b110, 32'h3F400000}
                || start_cnt !== sc || nn_start !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: got vld/bit/to=%b data=%h starts=%0d want 110 3f400000 %0d",
                         i, {resp_valid, resp_bit, resp_timeout}, resp_data, start_cnt, sc);
            end
        end
        take_resp(d, bt, to, ok);
        take_resp(d, bt, to, ok);
        total++;
        if (!ok || d !== 32'h3F000000 || bt !== 1'b0 || to !== 1'b0) begin
            bad++;
            $display("FAIL hold_second: got ok=%0d data=%h bit=%b to=%b want 3f000000 0 0",
                     ok, d, bt, to);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic bt, to;
        bit ok, last;
        int acc, c;
        model_never = 1;
        model_lat = 1;
        acc = 0;
        last = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1;
            req_a = 32'(i + 1);
            req_b = 32'h0;
            if (req_ready) acc++;
            last = req_ready;
        end
        @(negedge clk);
        req_valid = 0;
        total++;
        if (acc !== 5 || last !== 1'b0) begin
            bad++;
            $display("FAIL to_accept: got accepted=%0d ready6=%b want 5 0", acc, last);
        end
        take_resp(d, bt, to, ok);
        total++;
        if (!ok || d !== 32'h0 || bt !== 1'b0 || to !== 1'b1) begin
            bad++;
            $display("FAIL to_resp1: got ok=%0d data=%h bit=%b to=%b want 0 0 1",
                     ok, d, bt, to);
        end
        wait_start(ok);
        total++;
        if (!ok || nn_a !== 32'h2) begin
            bad++;
            $display("FAIL to_order: got ok=%0d nn_a=%h want 2", ok, nn_a);
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!resp_valid && c < 200);
        total++;
        if (c !== 65 || resp_timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_latency: got cycles=%0d to=%b want 65 1", c, resp_timeout);
        end
        do_reset();
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL to_flush: got busy=%b rdy=%b vld=%b want 0 1 0",
                     busy, req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_wait();
        bit ok, seen;
        cfg_write(4'd0, 32'h12345678);
        model_never = 1;
        push(32'h7, 32'h8, ok);
        wait_start(ok);
        repeat (3) @(negedge clk);
        rst_l = 0;
        @(negedge clk);
        rst_l = 1;
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0
            || nn_w11 !== 32'h0 || nn_a !== 32'h0) begin
            bad++;
            $display("FAIL rstwait_state: got busy=%b rdy=%b vld=%b w11=%h a=%h want 0 1 0 0 0",
                     busy, req_ready, resp_valid, nn_w11, nn_a);
        end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (resp_valid || nn_start) seen = 1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rstwait_quiet: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_cfg_busy();
        bit ok;
        model_never = 1;
        push(32'h3, 32'h4, ok);
        wait_start(ok);
        cfg_write(4'd0, 32'hAAAA5555);
        total++;
        if (nn_w11 !== 32'h0) begin
            bad++;
            $display("FAIL cfg_busy: got w11=%h want 0", nn_w11);
        end
        do_reset();
        cfg_write(4'd0, 32'hAAAA5555);
        total++;
        if (nn_w11 !== 32'hAAAA5555) begin
            bad++;
            $display("FAIL cfg_idle: got w11=%h want aaaa5555", nn_w11);
        end
        cfg_write(4'd9, 32'h6);
        cfg_write(4'd8, 32'h5A5A0000);
        cfg_write(4'd10, 32'hFFFFFFFF);
        total++;
        if (nn_round_mode !== 3'd6 || nn_b3 !== 32'h5A5A0000 || nn_w11 !== 32'hAAAA5555) begin
            bad++;
            $display("FAIL cfg_addr10: got rm=%0d b3=%h w11=%h want 6 5a5a0000 aaaa5555",
                     nn_round_mode, nn_b3, nn_w11);
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_threshold();
        test_hold();
        test_timeout();
        test_reset_wait();
        test_cfg_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
